spi_slave_fifo: RTL and testbench

Parametrised SPI slave: word width, bit order and idle fill value are configurable, and buffering is added on both sides. A DEPTH-entry TX FIFO feeds the shift register; a DEPTH-entry RX FIFO collects received words. Back-to-back words are supported inside one select window. The whole block runs in the SPI serial-clock domain. It sits between the SPI pins and the accelerator-side word interface, and replaces the fixed 8-bit, single-word slave.

---
 rtl/spi_slave_fifo_if.sv | 29 ++
 rtl/spi_slave_fifo.sv | 124 ++++++++++++
 tb/tb_spi_slave_fifo.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_fifo_if.sv
// Word-side and pin-side signals of spi_slave_fifo, grouped for port connection.
// The slave modport is the block's own view; master is the surrounding logic.
interface spi_slave_fifo_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ss;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             busy;
  logic             tx_underrun;
  logic             rx_overflow;
  logic             clr_err;

  modport slave (
    input  ss, mosi, tx_data, tx_valid, rx_ready, clr_err,
    output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overflow
  );

  modport master (
    output ss, mosi, tx_data, tx_valid, rx_ready, clr_err,
    input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overflow
  );
endinterface

// File: rtl/spi_slave_fifo.sv
// SPI slave with TX/RX word FIFOs, clocked entirely by sclk. Supports back-to-back
// words within one select window; configurable width, bit order and idle fill.
module spi_slave_fifo #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter bit               LSB_FIRST = 1'b0,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic            sclk,
  input  logic            rst,
  spi_slave_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_in;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    tx_wptr_q, tx_rptr_q;
  logic [AW:0]      tx_cnt_q;
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    rx_wptr_q, rx_rptr_q;
  logic [AW:0]      rx_cnt_q;
  logic             tx_underrun_q, rx_overflow_q;

  logic in_shift, last_bit, load;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;

  assign in_shift = (state_q == ST_SHIFT);
  assign last_bit = in_shift && bus.ss && (cnt_q == CW'(WIDTH - 1));
  // A completion edge reloads immediately so the next word needs exactly WIDTH edges.
  assign load     = bus.ss && (!in_shift || last_bit);

  assign tx_full  = (tx_cnt_q == (AW+1)'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (AW+1)'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_push  = bus.tx_valid && !tx_full;
  assign tx_pop   = load && !tx_empty;
  assign rx_push  = last_bit && !rx_full;
  assign rx_pop   = bus.rx_ready && !rx_empty;

  // Shifted value doubles as the received word on the completion edge.
  assign shreg_in = LSB_FIRST ? {bus.mosi, shreg_q[WIDTH-1:1]}
                              : {shreg_q[WIDTH-2:0], bus.mosi};

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (load) begin
        shreg_q <= tx_empty ? IDLE_WORD : tx_mem[tx_rptr_q];
        cnt_q   <= '0;
      end else if (in_shift && bus.ss) begin
        shreg_q <= shreg_in;
        cnt_q   <= cnt_q + CW'(1);
      end else begin
        cnt_q   <= '0;
      end
      state_q <= bus.ss ? ST_SHIFT : ST_IDLE;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) tx_mem[i] <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr_q] <= bus.tx_data;
        tx_wptr_q         <= tx_wptr_q + AW'(1);
      end
      if (tx_pop) tx_rptr_q <= tx_rptr_q + AW'(1);
      if (tx_push != tx_pop) tx_cnt_q <= tx_push ? tx_cnt_q + (AW+1)'(1) : tx_cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr_q] <= shreg_in;
        rx_wptr_q         <= rx_wptr_q + AW'(1);
      end
      if (rx_pop) rx_rptr_q <= rx_rptr_q + AW'(1);
      if (rx_push != rx_pop) rx_cnt_q <= rx_push ? rx_cnt_q + (AW+1)'(1) : rx_cnt_q - (AW+1)'(1);
    end
  end

  // Set takes priority over a simultaneous clear.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      tx_underrun_q <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      tx_underrun_q <= (load && tx_empty) || (tx_underrun_q && !bus.clr_err);
      rx_overflow_q <= (last_bit && rx_full) || (rx_overflow_q && !bus.clr_err);
    end
  end

  assign bus.miso        = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign bus.tx_ready    = !tx_full;
  assign bus.rx_data     = rx_mem[rx_rptr_q];
  assign bus.rx_valid    = !rx_empty;
  assign bus.busy        = in_shift;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.rx_overflow = rx_overflow_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: an MSB-first and an LSB-first instance share stimulus and are
// compared every cycle against a list-based model, plus directed scenario checks.
module tb_spi_slave_fifo;
  localparam int W = 8;
  localparam int D = 4;
  localparam logic [7:0] IDLE0 = 8'hFF;
  localparam logic [7:0] IDLE1 = 8'h5A;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  logic ss = 1'b0, mosi = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0, clr_err = 1'b0;
  logic [7:0] tx_data = '0;

  always #5 sclk = ~sclk;

  spi_slave_fifo_if #(.WIDTH(W)) bus0 ();
  spi_slave_fifo_if #(.WIDTH(W)) bus1 ();

  assign bus0.ss = ss;  assign bus0.mosi = mosi;  assign bus0.tx_data = tx_data;
  assign bus0.tx_valid = tx_valid;  assign bus0.rx_ready = rx_ready;  assign bus0.clr_err = clr_err;
  assign bus1.ss = ss;  assign bus1.mosi = mosi;  assign bus1.tx_data = tx_data;
  assign bus1.tx_valid = tx_valid;  assign bus1.rx_ready = rx_ready;  assign bus1.clr_err = clr_err;

  spi_slave_fifo #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(1'b0), .IDLE_WORD(IDLE0)) u_msb (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus0)
  );

  spi_slave_fifo #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(1'b1), .IDLE_WORD(IDLE1)) u_lsb (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFOs are ordered lists, the word on the wire is tracked as
  // (loaded word, bits already sent), received bits are kept in arrival order.
  logic [7:0] m_txl [D];
  int         m_txn;
  logic [7:0] m_rxl [2][D];
  int         m_rxn;
  logic [7:0] m_cur [2];
  int         m_sh, m_cnt;
  logic       m_busy, m_und, m_ovf;
  logic       m_bits [W];

  function automatic logic [7:0] assemble(input int k);
    logic [7:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (k == 0) w[W-1-i] = m_bits[i];
      else        w[i]     = m_bits[i];
    end
    return w;
  endfunction

  function automatic void model_reset();
    m_txn = 0; m_rxn = 0; m_sh = 0; m_cnt = 0;
    m_busy = 1'b0; m_und = 1'b0; m_ovf = 1'b0;
    m_cur[0] = '0; m_cur[1] = '0;
    for (int i = 0; i < D; i++) begin
      m_txl[i] = '0; m_rxl[0][i] = '0; m_rxl[1][i] = '0;
    end
  endfunction

  function automatic void model_step();
    logic done, load, txe, txf, rxf, und_set, ovf_set;
    done    = m_busy && ss && (m_cnt == W - 1);
    load    = ss && (!m_busy || done);
    txe     = (m_txn == 0);
    txf     = (m_txn == D);
    rxf     = (m_rxn == D);
    und_set = load && txe;
    ovf_set = done && rxf;
    if (m_busy && ss) m_bits[m_cnt] = mosi;
    if (rx_ready && m_rxn > 0) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < D - 1; i++) m_rxl[k][i] = m_rxl[k][i+1];
      m_rxn--;
    end
    if (done && !rxf) begin
      m_rxl[0][m_rxn] = assemble(0);
      m_rxl[1][m_rxn] = assemble(1);
      m_rxn++;
    end
    if (load) begin
      if (txe) begin
        m_cur[0] = IDLE0; m_cur[1] = IDLE1;
      end else begin
        m_cur[0] = m_txl[0]; m_cur[1] = m_txl[0];
        for (int i = 0; i < D - 1; i++) m_txl[i] = m_txl[i+1];
        m_txn--;
      end
      m_sh = 0;
    end else if (m_busy && ss) begin
      m_sh++;
    end
    if (tx_valid && !txf) begin
      m_txl[m_txn] = tx_data;
      m_txn++;
    end
    m_und  = und_set || (m_und && !clr_err);
    m_ovf  = ovf_set || (m_ovf && !clr_err);
    m_cnt  = (m_busy && ss && !done) ? m_cnt + 1 : 0;
    m_busy = ss;
  endfunction

  task automatic check_outs(input string p, input logic miso, busy, txr, rxv,
                            input logic [7:0] rxd, input logic und, ovf,
                            input logic e_miso, e_busy, e_txr, e_rxv,
                            input logic [7:0] e_rxd, input logic c_rxd, input logic e_und, e_ovf);
    check({p, ".miso"}, miso, e_miso);
    check({p, ".busy"}, busy, e_busy);
    check({p, ".tx_ready"}, txr, e_txr);
    check({p, ".rx_valid"}, rxv, e_rxv);
    if (c_rxd) check({p, ".rx_data"}, rxd, e_rxd);
    check({p, ".tx_underrun"}, und, e_und);
    check({p, ".rx_overflow"}, ovf, e_ovf);
  endtask

  task automatic check_all();
    check_outs("msb", bus0.miso, bus0.busy, bus0.tx_ready, bus0.rx_valid, bus0.rx_data,
               bus0.tx_underrun, bus0.rx_overflow, m_cur[0][W-1-m_sh], m_busy, m_txn < D,
               m_rxn > 0, m_rxl[0][0], m_rxn > 0, m_und, m_ovf);
    check_outs("lsb", bus1.miso, bus1.busy, bus1.tx_ready, bus1.rx_valid, bus1.rx_data,
               bus1.tx_underrun, bus1.rx_overflow, m_cur[1][m_sh], m_busy, m_txn < D,
               m_rxn > 0, m_rxl[1][0], m_rxn > 0, m_und, m_ovf);
  endtask

  // Called at a negedge: apply inputs, let one posedge happen, check at the next negedge.
  task automatic cycle(input logic s, m, tv, input logic [7:0] td, input logic rr, ce);
    ss = s; mosi = m; tx_valid = tv; tx_data = td; rx_ready = rr; clr_err = ce;
    @(posedge sclk);
    model_step();
    @(negedge sclk);
    check_all();
  endtask

  task automatic do_reset();
    ss = 0; mosi = 0; tx_valid = 0; tx_data = '0; rx_ready = 0; clr_err = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outs("rst0", bus0.miso, bus0.busy, bus0.tx_ready, bus0.rx_valid, bus0.rx_data,
               bus0.tx_underrun, bus0.rx_overflow, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_outs("rst1", bus1.miso, bus1.busy, bus1.tx_ready, bus1.rx_valid, bus1.rx_data,
               bus1.tx_underrun, bus1.rx_overflow, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b0;
    @(posedge sclk);
    model_step();
    @(negedge sclk);
  endtask

  // Eight shift edges with ss held; miso is reassembled into the word each instance sent.
  task automatic frame_word(input logic [7:0] mo, output logic [7:0] g0, output logic [7:0] g1);
    g0 = '0; g1 = '0;
    for (int i = 0; i < W; i++) begin
      g0 = {g0[6:0], bus0.miso};
      g1 = {bus1.miso, g1[7:1]};
      cycle(1'b1, mo[7-i], 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] g0, g1, h0, h1, wa, wb;
    logic       s_r;
    @(negedge sclk);
    do_reset();

    // Single word, MSB/LSB first: 0xA5 out, 0x3C in.
    cycle(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("s1.underrun_after_load", bus0.tx_underrun, 1'b0);
    frame_word(8'h3C, g0, g1);
    check("s1.miso_msb", g0, 8'hA5);
    check("s1.miso_lsb", g1, 8'hA5);
    check("s1.rx_valid", bus0.rx_valid, 1'b1);
    check("s1.rx_data_msb", bus0.rx_data, 8'h3C);
    check("s1.rx_data_lsb", bus1.rx_data, 8'h3C);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Back-to-back words inside one select window.
    cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    frame_word(8'hF0, g0, g1);
    frame_word(8'h0F, h0, h1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("s2.miso0_msb", g0, 8'h11);
    check("s2.miso1_msb", h0, 8'h22);
    check("s2.miso0_lsb", g1, 8'h11);
    check("s2.miso1_lsb", h1, 8'h22);
    check("s2.rx0_msb", bus0.rx_data, 8'hF0);
    check("s2.rx0_lsb", bus1.rx_data, 8'h0F);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("s2.rx1_msb", bus0.rx_data, 8'h0F);
    check("s2.rx1_lsb", bus1.rx_data, 8'hF0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Underrun: empty TX FIFO sends the idle word and latches the flag.
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    frame_word(8'($urandom), g0, g1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("s3.idle_msb", g0, IDLE0);
    check("s3.idle_lsb", g1, IDLE1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("s3.underrun_sticky", bus0.tx_underrun, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("s3.underrun_cleared", bus0.tx_underrun, 1'b0);

    // Overflow: fill TX, then receive five words without popping.
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    check("s4.tx_full_msb", bus0.tx_ready, 1'b0);
    check("s4.tx_full_lsb", bus1.tx_ready, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) frame_word(8'($urandom), g0, g1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("s4.overflow_msb", bus0.rx_overflow, 1'b1);
    check("s4.overflow_lsb", bus1.rx_overflow, 1'b1);
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("s4.rx_drained", bus0.rx_valid, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Abort after three shift edges; the next frame carries the next TX word.
    wa = 8'h96; wb = 8'h3B;
    cycle(1'b0, 1'b0, 1'b1, wa, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, wb, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'(i), 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("s5.busy_after_abort", bus0.busy, 1'b0);
    check("s5.no_rx_push", bus0.rx_valid, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    frame_word(8'($urandom), g0, g1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("s5.next_word_msb", g0, wb);
    check("s5.next_word_lsb", g1, wb);

    // Asynchronous reset in the middle of a word.
    cycle(1'b0, 1'b0, 1'b1, 8'hC7, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h5E, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();

    // Randomised traffic with frames of arbitrary length.
    s_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (s_r) s_r = ($urandom_range(29) != 0);
      else     s_r = ($urandom_range(3) == 0);
      cycle(s_r, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom),
            ($urandom_range(9) < 4), ($urandom_range(31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
